// File: rtl/bcd_up_down_counter_if.sv
// Bus between a controller and the BCD up/down counter: control inputs
// (enable, direction, parallel load) and the registered count outputs.
interface bcd_up_down_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  tick;
    logic                  wrap;

    // Controller side: drives the controls, observes the count.
    modport master (
        output en,
        output up,
        output load,
        output load_val,
        input  bcd,
        input  tick,
        input  wrap
    );

    // Counter side: consumes the controls, produces the count.
    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        output bcd,
        output tick,
        output wrap
    );
endinterface

// File: rtl/bcd_up_down_counter.sv
// Multi-digit prescaled BCD up/down counter. Each digit is a 4-bit BCD
// nibble that never leaves 0..9; a single-cycle carry/borrow ripple moves
// the whole count by one per prescaler period. Parallel load sanitizes
// illegal nibbles to 0 and overrides counting; reset overrides everything.
module bcd_up_down_counter #(
    parameter int          DIGITS   = 4,
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_up_down_counter_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    // Prescaler width: ceil(log2(PRESCALE)), never below one bit.
    localparam int PW = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    // Registered state
    logic [PW-1:0] r_pcnt;
    logic [W-1:0]  r_bcd;
    logic          r_tick;
    logic          r_wrap;

    // Combinational next-value terms
    logic          w_step;
    logic [DIGITS:0] w_carry;
    logic [DIGITS:0] w_borrow;
    logic [W-1:0]  w_inc_val;
    logic [W-1:0]  w_dec_val;
    logic [W-1:0]  w_load_san;
    logic [W-1:0]  w_step_val;
    logic          w_step_wrap;

    assign w_step = bus.en && (r_pcnt == PMAX);

    // Digit 0 always takes part in a step; higher digits only when every
    // digit below them rolls over.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_d;
            logic [3:0] w_lv;
            logic       w_at9;
            logic       w_at0;

            assign w_d   = r_bcd[4*gi +: 4];
            assign w_lv  = bus.load_val[4*gi +: 4];
            assign w_at9 = (w_d == 4'd9);
            assign w_at0 = (w_d == 4'd0);

            // Up path: increment when carried into, 9 wraps to 0 and carries on.
            assign w_inc_val[4*gi +: 4] = !w_carry[gi] ? w_d :
                                          (w_at9 ? 4'd0 : w_d + 4'd1);
            assign w_carry[gi+1]        = w_carry[gi] && w_at9;

            // Down path: decrement when borrowed from, 0 wraps to 9 and borrows on.
            assign w_dec_val[4*gi +: 4] = !w_borrow[gi] ? w_d :
                                          (w_at0 ? 4'd9 : w_d - 4'd1);
            assign w_borrow[gi+1]       = w_borrow[gi] && w_at0;

            // Load nibbles above 9 are not legal BCD; they load as 0.
            assign w_load_san[4*gi +: 4] = (w_lv > 4'd9) ? 4'd0 : w_lv;
        end
    endgenerate

    assign w_step_val  = bus.up ? w_inc_val : w_dec_val;
    assign w_step_wrap = bus.up ? w_carry[DIGITS] : w_borrow[DIGITS];

    // Prescaler: restarts on reset, load and step; freezes while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (bus.load) begin
            r_pcnt <= '0;
        end else if (bus.en) begin
            if (w_step)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + 1'b1;
        end
    end

    // Count register and step/terminal pulses, in reset > load > enable priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd  <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_bcd  <= w_load_san;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (!bus.en) begin
            // Count and wrap hold while paused; only tick drops.
            r_tick <= 1'b0;
        end else if (w_step) begin
            r_bcd  <= w_step_val;
            r_tick <= 1'b1;
            r_wrap <= w_step_wrap;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign bus.bcd  = r_bcd;
    assign bus.tick = r_tick;
    assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_bcd_up_down_counter.sv
// Directed bench for bcd_up_down_counter: one instance with PRESCALE=4 and
// one with PRESCALE=1, both four digits, sharing clock and reset.
module tb_bcd_up_down_counter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_up_down_counter_if #(.DIGITS(4)) if4 ();
    bcd_up_down_counter_if #(.DIGITS(4)) if1 ();

    bcd_up_down_counter #(.DIGITS(4), .PRESCALE(4)) u_p4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    bcd_up_down_counter #(.DIGITS(4), .PRESCALE(1)) u_p1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] exp_bcd;

        rst = 1'b1;
        if4.en = 1'b0; if4.up = 1'b1; if4.load = 1'b0; if4.load_val = '0;
        if1.en = 1'b0; if1.up = 1'b1; if1.load = 1'b0; if1.load_val = '0;
        cyc(2);
        chk("rst_bcd",  {16'd0, if4.bcd}, 32'h0);
        chk("rst_tick", {31'd0, if4.tick}, 32'h0);
        chk("rst_wrap", {31'd0, if4.wrap}, 32'h0);

        // Count up with PRESCALE=4: tick every 4th cycle, 0x0001..0x0010.
        rst = 1'b0;
        if4.en = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            cyc(3);
            chk("cnt_tick_idle", {31'd0, if4.tick}, 32'h0);
            cyc(1);
            exp_bcd = (s < 10) ? 16'(s) : 16'h0010;
            chk("cnt_tick", {31'd0, if4.tick}, 32'h1);
            chk("cnt_bcd",  {16'd0, if4.bcd}, {16'd0, exp_bcd});
            chk("cnt_wrap", {31'd0, if4.wrap}, 32'h0);
        end
        if4.en = 1'b0;

        // Up rollover with PRESCALE=1.
        if1.load = 1'b1; if1.load_val = 16'h9998; if1.en = 1'b1;
        cyc(1);
        chk("ld9998_bcd",  {16'd0, if1.bcd}, 32'h9998);
        chk("ld9998_tick", {31'd0, if1.tick}, 32'h0);
        if1.load = 1'b0; if1.up = 1'b1;
        cyc(1);
        chk("up_9999",      {16'd0, if1.bcd}, 32'h9999);
        chk("up_9999_wrap", {31'd0, if1.wrap}, 32'h0);
        cyc(1);
        chk("up_0000",      {16'd0, if1.bcd}, 32'h0000);
        chk("up_0000_wrap", {31'd0, if1.wrap}, 32'h1);
        chk("up_0000_tick", {31'd0, if1.tick}, 32'h1);
        cyc(1);
        chk("up_0001",      {16'd0, if1.bcd}, 32'h0001);
        chk("up_0001_wrap", {31'd0, if1.wrap}, 32'h0);
        chk("p1_tick_cont", {31'd0, if1.tick}, 32'h1);

        // Down borrow and rollover.
        if1.en = 1'b0; if1.load = 1'b1; if1.load_val = 16'h0100;
        cyc(1);
        chk("ld0100", {16'd0, if1.bcd}, 32'h0100);
        if1.load = 1'b0; if1.up = 1'b0; if1.en = 1'b1;
        cyc(1);
        chk("dn_0099",      {16'd0, if1.bcd}, 32'h0099);
        chk("dn_0099_wrap", {31'd0, if1.wrap}, 32'h0);
        if1.en = 1'b0; if1.load = 1'b1; if1.load_val = 16'h0000;
        cyc(1);
        chk("ld0000", {16'd0, if1.bcd}, 32'h0000);
        if1.load = 1'b0; if1.en = 1'b1;
        cyc(1);
        chk("dn_9999",      {16'd0, if1.bcd}, 32'h9999);
        chk("dn_9999_wrap", {31'd0, if1.wrap}, 32'h1);
        chk("dn_9999_tick", {31'd0, if1.tick}, 32'h1);
        if1.en = 1'b0;
        cyc(1);
        chk("pause_tick",      {31'd0, if1.tick}, 32'h0);
        chk("pause_wrap_hold", {31'd0, if1.wrap}, 32'h1);
        chk("pause_bcd_hold",  {16'd0, if1.bcd}, 32'h9999);

        // Load in a step cycle with illegal nibbles (PRESCALE=4).
        if4.en = 1'b1; if4.up = 1'b1;
        cyc(3);
        chk("pre_ld_tick", {31'd0, if4.tick}, 32'h0);
        if4.load = 1'b1; if4.load_val = 16'hA3F7;
        cyc(1);
        chk("ld_san_bcd",  {16'd0, if4.bcd}, 32'h0307);
        chk("ld_san_tick", {31'd0, if4.tick}, 32'h0);
        if4.load = 1'b0;
        cyc(3);
        chk("ld_next_idle", {31'd0, if4.tick}, 32'h0);
        cyc(1);
        chk("ld_next_tick", {31'd0, if4.tick}, 32'h1);
        chk("ld_next_bcd",  {16'd0, if4.bcd}, 32'h0308);

        // Enable pause: 2 enabled cycles, 10 paused, step 2 cycles after restore.
        cyc(2);
        chk("ep_pre_tick", {31'd0, if4.tick}, 32'h0);
        if4.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("ep_pause_bcd", {16'd0, if4.bcd}, 32'h0308);
        end
        chk("ep_pause_tick", {31'd0, if4.tick}, 32'h0);
        if4.en = 1'b1;
        cyc(1);
        chk("ep_resume1_tick", {31'd0, if4.tick}, 32'h0);
        cyc(1);
        chk("ep_resume2_tick", {31'd0, if4.tick}, 32'h1);
        chk("ep_resume2_bcd",  {16'd0, if4.bcd}, 32'h0309);

        // Reset mid-operation with bcd=0x0456 and pcnt=2.
        if4.load = 1'b1; if4.load_val = 16'h0456;
        cyc(1);
        chk("ld0456", {16'd0, if4.bcd}, 32'h0456);
        if4.load = 1'b0; if4.en = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("mrst_bcd",  {16'd0, if4.bcd}, 32'h0);
        chk("mrst_tick", {31'd0, if4.tick}, 32'h0);
        chk("mrst_wrap", {31'd0, if4.wrap}, 32'h0);
        rst = 1'b0;
        cyc(3);
        chk("mrst_idle_tick", {31'd0, if4.tick}, 32'h0);
        cyc(1);
        chk("mrst_step_tick", {31'd0, if4.tick}, 32'h1);
        chk("mrst_step_bcd",  {16'd0, if4.bcd}, 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_up_down_counter.md
# bcd_up_down_counter

Multi-digit, prescaled BCD up/down counter that generates the digit values fed to the 7-segment decoder stage, one 4-bit BCD nibble per digit. Every output nibble is always a legal BCD value, 0–9, so the downstream decoder never receives an undefined code. The block provides a synchronous parallel load, a single-cycle step pulse and a terminal-count pulse for cascading or for status LEDs.

## Interface
- `DIGITS`, default 4: number of BCD digits; valid range 1–8.
- `PRESCALE`, default 50_000_000: enabled clock cycles per count step; valid range 1 to 2^32−1.
- `clk`  in  1  system clock; every register changes only on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `en`  in  1  count enable; gates the prescaler.
- `up`  in  1  direction: 1 = increment, 0 = decrement; sampled at the step edge.
- `load`  in  1  synchronous parallel load; takes priority over counting.
- `load_val`  in  4*DIGITS  load value; digit 0 (least significant) is bits [3:0].
- `bcd`  out  4*DIGITS  registered count; digit k is bits [4k+3:4k].
- `tick`  out  1  registered one-cycle pulse, high in the cycle the new count first appears.
- `wrap`  out  1  registered one-cycle pulse, high with `tick` when the step rolled over (9…9→0…0 up, 0…0→9…9 down).

## Operation
- Prescaler register `pcnt`, width ceil(log2(PRESCALE)) with a minimum of 1; range 0..PRESCALE−1.
- Step condition: `step = en && (pcnt == PRESCALE−1)`.
- Evaluation order on each edge, highest priority first:
  1. `rst`: `bcd` = 0, `pcnt` = 0, `tick` = 0, `wrap` = 0.
  2. `load`: each digit of `bcd` takes its `load_val` nibble; a nibble greater than 9 loads as 0. `pcnt` = 0, `tick` = 0, `wrap` = 0. `en` and `up` are ignored this cycle.
  3. `en` = 0: `pcnt`, `bcd` and `wrap` hold; `tick` = 0.
  4. `en` = 1 and not `step`: `pcnt` increments; `bcd` holds; `tick` = 0, `wrap` = 0.
  5. `step`: `pcnt` = 0; `bcd` steps once in the direction given by `up`; `tick` = 1; `wrap` = 1 only when the step was terminal.
- Up step, ripple per digit:
  - Digit 0 always receives a carry.
  - A digit receiving a carry increments; at 9 it becomes 0 and passes a carry to the next digit.
  - A carry out of the top digit sets `wrap`; the count becomes all zeros.
- Down step, mirror of the up step:
  - Digit 0 always receives a borrow.
  - A digit receiving a borrow decrements; at 0 it becomes 9 and passes a borrow to the next digit.
  - A borrow out of the top digit sets `wrap`; the count becomes all nines.
- All carry and borrow logic is combinational within a single cycle; there is no multi-cycle ripple.
- Invariant: each `bcd` nibble is ≤ 9 in every cycle after reset.

## Timing
- Reset values: `bcd` = 0, `tick` = 0, `wrap` = 0, `pcnt` = 0. The first step occurs PRESCALE enabled cycles after reset is released.
- Step latency: with `en` held high, a step occurs every PRESCALE cycles. The new `bcd`, `tick` and `wrap` are all visible in the cycle after the step edge.
- `PRESCALE` = 1: a step on every enabled cycle; `tick` stays high continuously while `en` = 1.
- Disabling `en` mid-interval freezes `pcnt`. Re-enabling resumes the count, so total enabled cycles between steps is always PRESCALE.
- `load` in the same cycle as a step: the load wins. No step occurs, `tick` = 0, and the prescaler restarts from 0.
- `rst` in the same cycle as `load` or a step: the reset wins.
- `load` output: the loaded value appears in the next cycle. The next step follows PRESCALE enabled cycles later.
- Toggling `up` between steps has no effect until the next step edge.

## Test plan
- Reset and count (DIGITS=4, PRESCALE=4): hold `en`=1, `up`=1 after reset.
  - `tick` rises every 4th cycle.
  - `bcd` runs 0x0000→0x0001→…→0x0009→0x0010.
  - `wrap` stays 0.
- Up rollover: load 0x9998, then count up with PRESCALE=1.
  - Sequence 0x9999, then 0x0000.
  - `wrap`=1 only in the cycle showing 0x0000.
- Down borrow and rollover: load 0x0100, then `up`=0 with PRESCALE=1.
  - Step gives 0x0099.
  - Load 0x0000 and step gives 0x9999 with `wrap`=1.
- Load sanitization and priority: `load_val`=0xA3F7 with `load`=1 in a step cycle.
  - Next `bcd` = 0x0307.
  - `tick`=0 that cycle.
  - Next `tick` comes 4 enabled cycles later (PRESCALE=4).
- Enable pause: PRESCALE=4; drop `en` for 10 cycles after 2 enabled cycles, then restore it.
  - The step occurs exactly 2 enabled cycles after restore.
  - `bcd` is unchanged during the pause.
- Reset mid-operation: assert `rst` while `bcd`=0x0456 and `pcnt`=2.
  - Next cycle: `bcd`=0x0000, `tick`=0, `wrap`=0.
  - The following step comes a full PRESCALE enabled cycles later.
